// File: rtl/dout_display.sv
// Captures CPU output bytes, converts them to sign + three decimal digits with a
// shift-add-3 engine, and scans them onto a 4-digit active-low 7-segment display.
// Optional: define DOUT_DISPLAY_LEADING_BLANK_EN to blank leading zero digits.
module dout_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int SIGNED      = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Dout,
    input  logic       Dval,
    output logic [6:0] Seg,
    output logic [3:0] An,
    output logic       Busy,
    output logic [7:0] Value
);

    localparam int         CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;

    state_t     state_q;
    logic       valid_q;
    logic       neg_q;
    logic [7:0] value_q;
    logic [7:0] shreg_q;
    logic [11:0] bcd_q;
    logic [2:0] iter_q;
    logic [3:0] units_q, tens_q, hund_q;
    logic       sign_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;

    logic        capture;
    logic        neg_in;
    logic [7:0]  mag_in;
    logic [11:0] bcd_adj;
    logic [19:0] dd_shift;
    logic [3:0]  hund_disp, tens_disp;

    // A byte is taken only when idle and it differs from what is already shown.
    assign capture = (state_q == IDLE) && Dval && (!valid_q || (Dout != value_q));
    assign neg_in  = (SIGNED != 0) && Dout[7];
    assign mag_in  = neg_in ? -Dout : Dout;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        dd_shift = {bcd_adj, shreg_q} << 1;
    end

    always_comb begin
        hund_disp = bcd_q[11:8];
        tens_disp = bcd_q[7:4];
`ifdef DOUT_DISPLAY_LEADING_BLANK_EN
        if (bcd_q[11:8] == 4'd0) hund_disp = BLANK;
        if (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) tens_disp = BLANK;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            neg_q   <= 1'b0;
            value_q <= 8'd0;
            shreg_q <= 8'd0;
            bcd_q   <= 12'd0;
            iter_q  <= 3'd0;
            units_q <= BLANK;
            tens_q  <= BLANK;
            hund_q  <= BLANK;
            sign_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        value_q <= Dout;
                        valid_q <= 1'b1;
                        neg_q   <= neg_in;
                        shreg_q <= mag_in;
                        bcd_q   <= 12'd0;
                        iter_q  <= 3'd0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q   <= dd_shift[19:8];
                    shreg_q <= dd_shift[7:0];
                    iter_q  <= iter_q + 3'd1;
                    if (iter_q == 3'd7) state_q <= UPD;
                end
                UPD: begin
                    hund_q  <= hund_disp;
                    tens_q  <= tens_disp;
                    units_q <= bcd_q[3:0];
                    sign_q  <= neg_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg_enc(input logic [3:0] code);
        case (code)
            4'd0:    seg_enc = 7'b1000000;
            4'd1:    seg_enc = 7'b1111001;
            4'd2:    seg_enc = 7'b0100100;
            4'd3:    seg_enc = 7'b0110000;
            4'd4:    seg_enc = 7'b0011001;
            4'd5:    seg_enc = 7'b0010010;
            4'd6:    seg_enc = 7'b0000010;
            4'd7:    seg_enc = 7'b1111000;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0010000;
            default: seg_enc = 7'b1111111;
        endcase
    endfunction

    // Seg is registered from the next index so it changes on the same edge as An.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        case (idx_d)
            2'd0:    seg_d = seg_enc(units_q);
            2'd1:    seg_d = seg_enc(tens_q);
            2'd2:    seg_d = seg_enc(hund_q);
            default: seg_d = sign_q ? 7'b0111111 : 7'b1111111;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            seg_q <= 7'b1111111;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
        end
    end

    assign An    = ~(4'b0001 << idx_q);
    assign Seg   = seg_q;
    assign Busy  = (state_q != IDLE);
    assign Value = value_q;

endmodule

// File: tb/tb_dout_display.sv
// Directed bench for dout_display: a signed and an unsigned instance share stimulus;
// a vector table plus hand-written sequences for re-capture, reset abort and scan timing.
module tb_dout_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000, SM = 7'b0111111, SB = 7'b1111111;
`ifdef DOUT_DISPLAY_LEADING_BLANK_EN
    localparam logic [6:0] HZ = SB, TZ = SB;
`else
    localparam logic [6:0] HZ = S0, TZ = S0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Dout  = 8'd0;
    logic       Dval  = 1'b0;
    logic [6:0] seg_s, seg_u;
    logic [3:0] an_s, an_u;
    logic       busy_s, busy_u;
    logic [7:0] value_s, value_u;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    dout_display #(.REFRESH_DIV(4), .SIGNED(1)) u_dut (
        .Clock(Clock), .Reset(Reset), .Dout(Dout), .Dval(Dval),
        .Seg(seg_s), .An(an_s), .Busy(busy_s), .Value(value_s)
    );

    dout_display #(.REFRESH_DIV(4), .SIGNED(0)) u_dut_u (
        .Clock(Clock), .Reset(Reset), .Dout(Dout), .Dval(Dval),
        .Seg(seg_u), .An(an_u), .Busy(busy_u), .Value(value_u)
    );

    typedef struct {
        logic [7:0]      dout;
        logic [3:0][6:0] exp_s;   // {sign, hundreds, tens, units}
        logic [3:0][6:0] exp_u;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a byte and measure how many sampled cycles Busy stays high.
    task automatic run_conv(input logic [7:0] d, output int busy_n);
        int t;
        Dout = d;
        Dval = 1'b1;
        busy_n = 0;
        t = 0;
        @(negedge Clock);
        while (!busy_s && t < 4) begin
            @(negedge Clock);
            t++;
        end
        while (busy_s && busy_n < 40) begin
            busy_n++;
            @(negedge Clock);
        end
        Dval = 1'b0;
    endtask

    // Watch a full scan and collect the segment pattern shown in each digit slot.
    task automatic read_display(output logic [3:0][6:0] ds, output logic [3:0][6:0] du);
        ds = '0;
        du = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            for (int k = 0; k < 4; k++) begin
                if (an_s == ~(4'b0001 << k)) ds[k] = seg_s;
                if (an_u == ~(4'b0001 << k)) du[k] = seg_u;
            end
        end
    endtask

    initial begin
        int              busy_n;
        logic [3:0][6:0] ds, du;
        logic [23:0]     bpat, bexp;
        int              rises, an_err;
        logic            prev;

        vecs[0] = '{8'h7B, {SB, S1, S2, S3}, {SB, S1, S2, S3}};
        vecs[1] = '{8'h80, {SM, S1, S2, S8}, {SB, S1, S2, S8}};
        vecs[2] = '{8'hFF, {SM, HZ, TZ, S1}, {SB, S2, S5, S5}};
        vecs[3] = '{8'h00, {SB, HZ, TZ, S0}, {SB, HZ, TZ, S0}};
        vecs[4] = '{8'h63, {SB, HZ, S9, S9}, {SB, HZ, S9, S9}};
        vecs[5] = '{8'h0A, {SB, HZ, S1, S0}, {SB, HZ, S1, S0}};
        vecs[6] = '{8'h9C, {SM, S1, S0, S0}, {SB, S1, S5, S6}};
        vecs[7] = '{8'hF6, {SM, HZ, S1, S0}, {SB, S2, S4, S6}};

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("reset_an", 32'(an_s), 32'(4'b1110));
        check("reset_seg", 32'(seg_s), 32'(SB));
        check("reset_busy", 32'(busy_s), 32'd0);
        check("reset_value", 32'(value_s), 32'd0);
        Reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_conv(vecs[v].dout, busy_n);
            check($sformatf("v%0d_busy_cycles", v), 32'(busy_n), 32'd9);
            check($sformatf("v%0d_value", v), 32'(value_s), 32'(vecs[v].dout));
            read_display(ds, du);
            check($sformatf("v%0d_digits_signed", v), 32'(ds), 32'(vecs[v].exp_s));
            check($sformatf("v%0d_digits_unsigned", v), 32'(du), 32'(vecs[v].exp_u));
        end

        // Dout changes mid-conversion: re-capture right after the first finishes
        Dout = 8'h05;
        Dval = 1'b1;
        bexp = '0;
        for (int i = 0; i < 9; i++) begin
            bexp[i]      = 1'b1;
            bexp[i + 10] = 1'b1;
        end
        for (int n = 0; n < 24; n++) begin
            @(negedge Clock);
            bpat[n] = busy_s;
            if (n == 2) Dout = 8'h06;
            if (n == 5) check("recap_first_value", 32'(value_s), 32'h05);
        end
        Dval = 1'b0;
        check("recap_busy_pattern", 32'(bpat), 32'(bexp));
        check("recap_second_value", 32'(value_s), 32'h06);
        read_display(ds, du);
        check("recap_digits", 32'(ds), 32'({SB, HZ, TZ, S6}));

        // Reset asserted mid-conversion aborts and blanks the display
        Dout = 8'h2A;
        Dval = 1'b1;
        for (int n = 0; n < 3; n++) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("abort_busy", 32'(busy_s), 32'd0);
        check("abort_an", 32'(an_s), 32'(4'b1110));
        check("abort_seg", 32'(seg_s), 32'(SB));
        check("abort_value", 32'(value_s), 32'd0);
        Reset = 1'b0;
        run_conv(8'h2A, busy_n);
        check("abort_recap_busy", 32'(busy_n), 32'd9);
        check("abort_recap_value", 32'(value_s), 32'h2A);
        read_display(ds, du);
        check("abort_recap_digits", 32'(ds), 32'({SB, HZ, S4, S2}));

        // Constant Dval/Dout: one conversion only, and the scan timing
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        Dout = 8'h2A;
        Dval = 1'b1;
        rises = 0;
        an_err = 0;
        prev = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clock);
            if (busy_s && !prev) rises++;
            prev = busy_s;
            if (an_s !== ~(4'b0001 << ((k / 4) % 4))) an_err++;
        end
        Dval = 1'b0;
        check("hold_busy_pulses", 32'(rises), 32'd1);
        check("hold_an_scan_errors", 32'(an_err), 32'd0);
        read_display(ds, du);
        check("hold_digits", 32'(ds), 32'({SB, HZ, S4, S2}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
